// File: rtl/sh_pkg.sv
// Shared constants and state encoding for the slot-synchronised OOK link (tx and rx sync).
package sh_pkg;
  localparam int PREAMBLE_SIZE    = 8;
  localparam int PACKET_SIZE      = 24;
  localparam int DEFAULT_INTERVAL = 10000;
  localparam int SLOT_W           = 14;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DONE     = 2'd3
  } sh_state_t;
endpackage

// File: rtl/sh_slot_timer.sv
// Free-running slot counter: counts 0..period-1 while enabled, flags the last cycle of each slot.
module sh_slot_timer
  import sh_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [SLOT_W-1:0] period,
  output logic              slot_end,
  output logic [SLOT_W-1:0] count
);
  assign slot_end = en && (count == period - 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= slot_end ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/sh_tx.sv
// OOK slot transmitter: 8 preamble pulses then 24 NRZ data bits, one bit per slot, MSB first.
module sh_tx #(
  parameter int PULSE_WIDTH      = 100,
  parameter int DEFAULT_INTERVAL = sh_pkg::DEFAULT_INTERVAL
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [23:0] data_in,
  input  logic [13:0] interval_in,
  output logic        tx_out,
  output logic        busy,
  output logic        tx_rdy,
  output logic        tx_done
);
  import sh_pkg::*;

  localparam logic [13:0] DEF_IVL = 14'(DEFAULT_INTERVAL);

  sh_state_t   state, state_nxt;
  logic [23:0] shift_reg;
  logic [13:0] ivl_reg, slot_cnt;
  logic [4:0]  bit_cnt;
  logic        slot_end, accept, tx_nxt, last_slot, timer_en, timer_clr;

  assign accept    = (state == ST_IDLE) && start && !abort;
  assign timer_en  = (state == ST_PREAMBLE) || (state == ST_DATA);
  assign timer_clr = !timer_en || abort;
  assign last_slot = (state == ST_PREAMBLE) ? (bit_cnt == 5'(PREAMBLE_SIZE - 1))
                                            : (bit_cnt == 5'(PACKET_SIZE - 1));

  sh_slot_timer u_slot_timer (
    .clk      (clk),
    .rst      (rst),
    .en       (timer_en),
    .clr      (timer_clr),
    .period   (ivl_reg),
    .slot_end (slot_end),
    .count    (slot_cnt)
  );

  // tx_nxt is the line level for the count/state/shift value that becomes current after this edge,
  // so the registered tx_out always lines up with slot_cnt.
  always_comb begin
    state_nxt = state;
    tx_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_PREAMBLE;
          tx_nxt    = 1'b1;
        end
      end
      ST_PREAMBLE: begin
        if (slot_end && last_slot) begin
          state_nxt = ST_DATA;
          tx_nxt    = shift_reg[23];
        end else if (slot_end) begin
          tx_nxt = 1'b1;
        end else begin
          tx_nxt = ({18'd0, slot_cnt} + 32'd1) < 32'(PULSE_WIDTH);
        end
      end
      ST_DATA: begin
        if (slot_end && last_slot) state_nxt = ST_DONE;
        else if (slot_end)         tx_nxt = shift_reg[22];
        else                       tx_nxt = shift_reg[23];
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) begin
      state_nxt = ST_IDLE;
      tx_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_out    <= 1'b0;
      shift_reg <= '0;
      ivl_reg   <= DEF_IVL;
      bit_cnt   <= '0;
    end else begin
      tx_out <= tx_nxt;
      if (accept) begin
        shift_reg <= data_in;
        ivl_reg   <= ({18'd0, interval_in} < 32'(2 * PULSE_WIDTH)) ? DEF_IVL : interval_in;
      end else if ((state == ST_DATA) && slot_end) begin
        shift_reg <= {shift_reg[22:0], 1'b0};
      end
      if (state_nxt != state) bit_cnt <= '0;
      else if (slot_end)      bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Gated by rst so no accept strobe can escape while reset holds the FSM in IDLE.
  assign tx_rdy  = accept && rst;
  assign busy    = (state != ST_IDLE);
  assign tx_done = (state == ST_DONE) && !abort;
endmodule

// File: tb/tb_sh_tx.sv
// Bench for sh_tx with scaled timing; expected line levels come from a per-cycle frame model.
module tb_sh_tx;
  localparam int PW  = 4;
  localparam int DEF = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [23:0] data_in = '0;
  logic [13:0] interval_in = '0;
  logic        tx_out, busy, tx_rdy, tx_done;
  int          n_chk = 0;
  int          n_fail = 0;

  sh_tx #(.PULSE_WIDTH(PW), .DEFAULT_INTERVAL(DEF)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .data_in     (data_in),
    .interval_in (interval_in),
    .tx_out      (tx_out),
    .busy        (busy),
    .tx_rdy      (tx_rdy),
    .tx_done     (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int eff_ivl(input int ivl);
    return (ivl < 2 * PW) ? DEF : ivl;
  endfunction

  // Line level t cycles after accept: 8 pulse slots, then 24 data slots MSB first, then low.
  function automatic logic exp_tx(input logic [23:0] d, input int ivl, input int t);
    int o, slot, pos;
    o    = t - 1;
    slot = o / ivl;
    pos  = o % ivl;
    if (t < 1)     return 1'b0;
    if (slot < 8)  return (pos < PW);
    if (slot < 32) return d[31 - slot];
    return 1'b0;
  endfunction

  // Called at an IDLE cycle (just after a negedge); accepts one frame and checks every cycle.
  task automatic run_frame(input logic [23:0] d, input int ivl_in, input int abort_t,
                           input int rst_t, input bit noise, input bit hold);
    int ivl, last;
    ivl  = eff_ivl(ivl_in);
    last = 32 * ivl + 1;
    start = 1'b1;
    data_in = d;
    interval_in = 14'(ivl_in);
    #1;
    check("accept_rdy", tx_rdy, 1);
    check("accept_busy", busy, 0);
    for (int t = 1; t <= last; t++) begin
      @(negedge clk);
      start = 1'b0;
      if (noise && ($urandom_range(0, 3) == 0)) begin
        start       = 1'($urandom_range(0, 1));
        data_in     = 24'($urandom);
        interval_in = 14'($urandom);
      end
      #1;
      check("tx_out", tx_out, exp_tx(d, ivl, t));
      check("busy", busy, 1);
      check("tx_done", tx_done, (t == last));
      check("tx_rdy", tx_rdy, 0);
      if (t == abort_t) begin
        start = 1'b0;
        abort = 1'b1;
        @(negedge clk);
        #1;
        check("abort_tx", tx_out, 0);
        check("abort_busy", busy, 0);
        check("abort_done", tx_done, 0);
        abort = 1'b0;
        repeat (4) begin
          @(negedge clk);
          #1;
          check("post_abort_busy", busy, 0);
          check("post_abort_done", tx_done, 0);
        end
        return;
      end
      if (t == rst_t) begin
        start = 1'b0;
        rst = 1'b0;
        #1;
        check("rst_tx", tx_out, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) begin
          @(negedge clk);
          #1;
          check("post_rst_tx", tx_out, 0);
          check("post_rst_busy", busy, 0);
        end
        return;
      end
      if (t == last) start = hold;
    end
    @(negedge clk);
    #1;
    check("gap_busy", busy, 0);
    check("gap_tx", tx_out, 0);
    check("gap_done", tx_done, 0);
    check("gap_rdy", tx_rdy, hold);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    start = 1'b1;
    @(negedge clk);
    #1;
    check("rst_tx_out", tx_out, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_rdy", tx_rdy, 0);
    check("rst_tx_done", tx_done, 0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_tx", tx_out, 0);

    run_frame(24'hA5C30F, 20, 0, 0, 1'b0, 1'b0);
    run_frame(24'h123456, 7, 0, 0, 1'b0, 1'b0);
    run_frame(24'hFFFFFF, 8, 0, 0, 1'b0, 1'b1);
    run_frame(24'h000001, 9, 0, 0, 1'b0, 1'b0);
    run_frame(24'h5A5A5A, 12, 13 * 12 + 6 + 1, 0, 1'b0, 1'b0);
    run_frame(24'hC0FFEE, 10, 0, 0, 1'b1, 1'b0);
    run_frame(24'h3C3C3C, 10, 0, 2 * 10 + 2, 1'b0, 1'b0);
    run_frame(24'h800000, 30, 0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      run_frame(24'($urandom), $urandom_range(5, 40), 0, 0,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    start = 1'b0;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/sh_tx.md
SH_TX -- requirements
Module: sh_tx

Interface
REQ-001 SHALL have parameter PULSE_WIDTH, default 100, preamble pulse high time in clk cycles (10 us at 10 MHz).
REQ-002 SHALL have parameter DEFAULT_INTERVAL, default 10000, slot period in clk cycles (1 ms) used when interval_in is invalid.
REQ-003 clk  input  1  system clock, 10 MHz, all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  level; accepted only in IDLE.
REQ-006 abort  input  1  level; cancels any transmission.
REQ-007 data_in  input  24  packet payload, MSB sent first, latched on accept.
REQ-008 interval_in  input  14  slot period in cycles, latched on accept.
REQ-009 tx_out  output  1  registered OOK line driven to the RF front end (receiver's rfin).
REQ-010 busy  output  1  high from accept until return to IDLE.
REQ-011 tx_rdy  output  1  one-cycle pulse on accept.
REQ-012 tx_done  output  1  one-cycle pulse on normal completion.

Function
REQ-013 SHALL implement states IDLE, PREAMBLE, DATA, DONE.
REQ-014 IDLE: tx_out=0, busy=0; start=1 and abort=0 -> PREAMBLE next cycle; latch data_in into shift_reg and interval_in into ivl_reg; tx_rdy=1 for that one cycle.
REQ-015 ivl_reg SHALL load DEFAULT_INTERVAL when interval_in < 2*PULSE_WIDTH, else interval_in.
REQ-016 slot_cnt (14 bit) SHALL count 0..ivl_reg-1 in PREAMBLE and DATA, wrap to 0, and assert slot_end at ivl_reg-1.
REQ-017 PREAMBLE: 8 slots (PREAMBLE_SIZE); tx_out=1 while slot_cnt < PULSE_WIDTH, else 0; first tx_out high in the cycle after accept.
REQ-018 Preamble rising edges SHALL be exactly ivl_reg cycles apart; after the 8th slot_end -> DATA with slot_cnt=0.
REQ-019 DATA: 24 slots (PACKET_SIZE); tx_out SHALL hold shift_reg[23] NRZ for the whole slot; shift_reg shifts left, zero fill, on slot_end.
REQ-020 Bit k of the packet SHALL be stable at receiver sample point slot_cnt = ivl_reg/2 (integer divide).
REQ-021 After the 24th slot_end -> DONE; DONE lasts one cycle with tx_out=0, tx_done=1, busy=1, then IDLE.
REQ-022 bit_cnt (5 bit) SHALL count slots within PREAMBLE (0..7) and DATA (0..23), cleared on every state change.
REQ-023 start while busy SHALL be ignored; data_in/interval_in changes while busy SHALL not affect the frame.
REQ-024 abort=1 in any state SHALL force IDLE next cycle, tx_out=0, busy=0, no tx_done; abort wins over simultaneous start.
REQ-025 start held high through DONE SHALL start a new frame from IDLE, giving at least one idle cycle between frames.
REQ-026 tx_rdy and tx_done SHALL never be high in the same cycle.

Reset
REQ-027 rst=0 SHALL asynchronously force IDLE, tx_out=0, busy=0, tx_rdy=0, tx_done=0, slot_cnt=0, bit_cnt=0, shift_reg=0, ivl_reg=DEFAULT_INTERVAL.
REQ-028 Reset asserted mid-frame SHALL drop tx_out the same instant; after release no frame resumes without a new start.

Structure
REQ-029 PREAMBLE_SIZE=8, PACKET_SIZE=24, DEFAULT_INTERVAL and state encodings SHALL live in a shared include shared with the receiver-side sync block.
REQ-030 slot_cnt and slot_end SHALL be one sub-module, sh_slot_timer (clk, rst, en, clr, period -> slot_end, count).

Verification
REQ-031 Reset then start, data_in=24'hA5C30F, interval_in=10000 -> 8 pulses of 100 cycles, period 10000, then 24 NRZ bits 1010_0101_1100_0011_0000_1111, tx_done at cycle 320001 after accept.
REQ-032 interval_in=150 (<200) -> preamble period measured as 10000.
REQ-033 abort pulsed in DATA bit 5 -> tx_out=0 and busy=0 next cycle, no tx_done.
REQ-034 start re-pulsed and data_in changed mid-frame -> ignored, original payload sent.
REQ-035 Loopback: tx_out into the receiver sync block's rfin, ext_counter_flag=0, interval_in=10000 -> its 24 sample pulses all land mid-slot and recover 24'hA5C30F.
REQ-036 rst asserted during PREAMBLE pulse 3 -> tx_out low immediately, IDLE after release, no output until next start.
